playfield_renderer: RTL and testbench
=====================================

PLAYFIELD_RENDERER -- requirements
Module: playfield_renderer

Interface
REQ-001 Parameter COLS, default 10, playfield width in cells.
REQ-002 Parameter ROWS, default 20, playfield height in cells.
REQ-003 Parameter CELL, default 20, cell edge in pixels.
REQ-004 Parameters X0/Y0, defaults 220/40, top-left pixel of playfield.
REQ-005 Parameters FLASH_FRAMES, default 4, frames per flash phase; FLASH_BLINKS, default 3, ON/OFF pairs per flash.
REQ-006 clk  in  1  pixel clock.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 vsync_start  in  1  one-cycle pulse at start of each frame.
REQ-009 blank_n  in  1  active-video flag, aligned with row/column.
REQ-010 row  in  9, column  in  10  current pixel coordinates.
REQ-011 cell_addr  out  clog2(COLS*ROWS)  board RAM address, row-major (r*COLS+c), combinational from row/column.
REQ-012 cell_code  in  3  board RAM data, valid one cycle after cell_addr; 0 = empty.
REQ-013 flash_req  in  1; flash_rows  in  ROWS  request line-clear flash of flagged rows.
REQ-014 flash_busy  out  1; flash_done  out  1  one-cycle pulse at flash end.
REQ-015 pal_we  in  1; pal_idx  in  3; pal_data  in  24  palette write port.
REQ-016 hit  out  1  pixel lies inside playfield (delayed with rgb).
REQ-017 red/green/blue  out  8 each  registered pixel colour.

Function
REQ-018 Pixel path latency exactly 2 cycles from row/column/blank_n to red/green/blue/hit.
REQ-019 Stage 1 registers in_board, cell column/row index (constant division by CELL), grid-line flag and blank_n.
REQ-020 in_board: X0 <= column < X0+COLS*CELL and Y0 <= row < Y0+ROWS*CELL; outside, cell_addr = 0 and hit = 0.
REQ-021 Grid line: in_board, cell_code == 0 and (column-X0) mod CELL == 0 with cell column > 0.
REQ-022 Colour priority: blank -> 0; !in_board -> 0; flashing row in ON phase -> 24'hFFFFFF; flashing row in OFF phase -> palette[0]; cell_code != 0 -> palette[cell_code]; grid line -> 24'hFFBEF0; else palette[0].
REQ-023 Palette: 8 x 24-bit registers; write on pal_we at clock edge; stage 2 reading same index that cycle uses old value.
REQ-024 Flash FSM states IDLE, ON, OFF.
REQ-025 IDLE + flash_req with flash_rows != 0 -> latch flash_rows, frame count 0, blink count 0, ON.
REQ-026 ON/OFF: each vsync_start increments frame count; at FLASH_FRAMES-th pulse, count clears and phase toggles.
REQ-027 OFF -> ON increments blink count; leaving OFF when blink count reaches FLASH_BLINKS-1 -> IDLE, one-cycle flash_done, latched rows cleared.
REQ-028 flash_req in ON/OFF ignored; flash_req with flash_rows == 0 ignored.
REQ-029 flash_busy = 1 in ON or OFF.
REQ-030 Phase change applies to the pixel entering stage 2 in the following cycle; no tearing requirement beyond that.

Reset
REQ-031 On rst low: FSM IDLE, counters 0, latched rows 0, pipeline flags 0, red/green/blue 0, hit 0, flash_busy 0, flash_done 0.
REQ-032 Palette reset: [0]=FFCCE5, [1]=66B2FF, [2]=FF3399, [3]=7F00FF, [4]=FFFF66, [5]=66FF66, [6]=990099, [7]=99FFCC.
REQ-033 Reset mid-flash aborts with no flash_done pulse.

Structure
REQ-034 Palette reset colours, grid colour, flash colour and state encodings live in shared package tetris_pkg.
REQ-035 Flash FSM is one sub-module, row_flash_ctrl; pixel pipeline and palette stay in the top.

Verification
REQ-036 Pixel (row 40, col 220), cell_code 3 -> two cycles later rgb 7F00FF, hit 1, cell_addr 0 issued.
REQ-037 Pixel (row 439, col 419), empty -> cell_addr 199, rgb FFCCE5; col 240, empty -> FFBEF0; col 440 -> rgb 0, hit 0.
REQ-038 flash_req, flash_rows = 1<<19, then 24 vsync_start pulses -> row 19 white for frames 1-4, 9-12, 17-20; flash_done exactly after pulse 24; flash_busy 1 throughout.
REQ-039 pal_we idx 3 data 123456 -> next cell_code 3 pixel after write shows 123456; same-cycle pixel shows old 7F00FF.
REQ-040 rst low after 6 pulses of a flash -> busy 0 immediately, no flash_done, rows render normally; flash_req during busy -> no restart.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared constants for the playfield renderer: flash FSM encoding, fixed colours,
// palette reset contents and a width helper.
package tetris_pkg;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_ON   = 2'd1,
    FL_OFF  = 2'd2
  } flash_state_e;

  localparam logic [23:0] GRID_RGB  = 24'hFFBEF0;
  localparam logic [23:0] FLASH_RGB = 24'hFFFFFF;

  // Entry [0] is the background colour; entries 1..7 are piece colours.
  localparam logic [7:0][23:0] PAL_INIT = {
    24'h99FFCC, 24'h990099, 24'h66FF66, 24'hFFFF66,
    24'h7F00FF, 24'hFF3399, 24'h66B2FF, 24'hFFCCE5
  };

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_flash_ctrl.sv
// Line-clear flash sequencer: alternates ON/OFF phases every FLASH_FRAMES frames
// for FLASH_BLINKS pairs, then pulses flash_done and releases the latched rows.
module row_flash_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS         = 20,
  parameter int FLASH_FRAMES = 4,
  parameter int FLASH_BLINKS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vsync_start,
  input  logic            flash_req,
  input  logic [ROWS-1:0] flash_rows,
  output logic [ROWS-1:0] rows_q,
  output logic            flash_on,
  output logic            flash_busy,
  output logic            flash_done
);

  localparam int FW = clog2_min1(FLASH_FRAMES);
  localparam int BW = clog2_min1(FLASH_BLINKS);

  flash_state_e    state, state_d;
  logic [FW-1:0]   frm, frm_d;
  logic [BW-1:0]   blk, blk_d;
  logic [ROWS-1:0] rows_d;
  logic            done_q, done_d;
  logic            phase_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FL_IDLE;
      frm    <= '0;
      blk    <= '0;
      rows_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      frm    <= frm_d;
      blk    <= blk_d;
      rows_q <= rows_d;
      done_q <= done_d;
    end
  end

  assign phase_end = vsync_start && (frm == FW'(FLASH_FRAMES - 1));

  always_comb begin
    state_d = state;
    frm_d   = frm;
    blk_d   = blk;
    rows_d  = rows_q;
    done_d  = 1'b0;
    case (state)
      FL_IDLE: begin
        if (flash_req && (|flash_rows)) begin
          rows_d  = flash_rows;
          frm_d   = '0;
          blk_d   = '0;
          state_d = FL_ON;
        end
      end
      FL_ON: begin
        if (phase_end) begin
          frm_d   = '0;
          state_d = FL_OFF;
        end else if (vsync_start) begin
          frm_d = frm + 1'b1;
        end
      end
      FL_OFF: begin
        if (phase_end) begin
          frm_d = '0;
          // Last OFF phase ends the sequence instead of starting another blink.
          if (blk == BW'(FLASH_BLINKS - 1)) begin
            state_d = FL_IDLE;
            blk_d   = '0;
            rows_d  = '0;
            done_d  = 1'b1;
          end else begin
            blk_d   = blk + 1'b1;
            state_d = FL_ON;
          end
        end else if (vsync_start) begin
          frm_d = frm + 1'b1;
        end
      end
      default: state_d = FL_IDLE;
    endcase
  end

  always_comb begin
    flash_busy = (state == FL_ON) || (state == FL_OFF);
    flash_on   = (state == FL_ON);
    flash_done = done_q;
  end

endmodule

// File: rtl/playfield_renderer.sv
// Two-stage pixel pipeline for the tetris playfield: board address generation and
// geometry in stage 1, palette/grid/flash colour resolution in stage 2.
module playfield_renderer
  import tetris_pkg::*;
#(
  parameter int  COLS         = 10,
  parameter int  ROWS         = 20,
  parameter int  CELL         = 20,
  parameter int  X0           = 220,
  parameter int  Y0           = 40,
  parameter int  FLASH_FRAMES = 4,
  parameter int  FLASH_BLINKS = 3,
  localparam int AW           = clog2_min1(COLS * ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vsync_start,
  input  logic            blank_n,
  input  logic [8:0]      row,
  input  logic [9:0]      column,
  output logic [AW-1:0]   cell_addr,
  input  logic [2:0]      cell_code,
  input  logic            flash_req,
  input  logic [ROWS-1:0] flash_rows,
  output logic            flash_busy,
  output logic            flash_done,
  input  logic            pal_we,
  input  logic [2:0]      pal_idx,
  input  logic [23:0]     pal_data,
  output logic            hit,
  output logic [7:0]      red,
  output logic [7:0]      green,
  output logic [7:0]      blue
);

  localparam int CW = clog2_min1(COLS);
  localparam int RW = clog2_min1(ROWS);

  logic [9:0]      col_off;
  logic [8:0]      row_off;
  logic            in_board;
  logic [CW-1:0]   cell_c;
  logic [RW-1:0]   cell_r;
  logic            on_line;

  logic            in_board_q, blank_q, line_q;
  logic [CW-1:0]   cell_c_q;
  logic [RW-1:0]   cell_r_q;

  logic [7:0][23:0] pal;
  logic [ROWS-1:0] rows_q;
  logic            flash_on;
  logic            row_fl;
  logic [23:0]     rgb_d, rgb_q;
  logic            hit_q;

  // Stage 0: geometry, combinational from the raster position.
  always_comb begin
    col_off  = column - 10'(X0);
    row_off  = row - 9'(Y0);
    in_board = ({22'd0, column} >= 32'(X0)) && ({22'd0, column} < 32'(X0 + COLS * CELL)) &&
               ({23'd0, row}    >= 32'(Y0)) && ({23'd0, row}    < 32'(Y0 + ROWS * CELL));
    cell_c   = CW'(col_off / 10'(CELL));
    cell_r   = RW'(row_off / 9'(CELL));
    on_line  = (col_off % 10'(CELL)) == 10'd0;
    cell_addr = in_board ? AW'(32'(cell_r) * 32'(COLS) + 32'(cell_c)) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_board_q <= 1'b0;
      blank_q    <= 1'b0;
      line_q     <= 1'b0;
      cell_c_q   <= '0;
      cell_r_q   <= '0;
    end else begin
      in_board_q <= in_board;
      blank_q    <= blank_n;
      line_q     <= on_line;
      cell_c_q   <= cell_c;
      cell_r_q   <= cell_r;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        pal <= PAL_INIT;
    else if (pal_we) pal[pal_idx] <= pal_data;
  end

  row_flash_ctrl #(
    .ROWS         (ROWS),
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_BLINKS (FLASH_BLINKS)
  ) u_flash (
    .clk         (clk),
    .rst         (rst),
    .vsync_start (vsync_start),
    .flash_req   (flash_req),
    .flash_rows  (flash_rows),
    .rows_q      (rows_q),
    .flash_on    (flash_on),
    .flash_busy  (flash_busy),
    .flash_done  (flash_done)
  );

  // Stage 2: cell_code has arrived from the board RAM; resolve colour by priority.
  assign row_fl = flash_busy && rows_q[cell_r_q];

  always_comb begin
    rgb_d = pal[0];
    if (!blank_q || !in_board_q)                           rgb_d = '0;
    else if (row_fl && flash_on)                           rgb_d = FLASH_RGB;
    else if (row_fl)                                       rgb_d = pal[0];
    else if (cell_code != 3'd0)                            rgb_d = pal[cell_code];
    else if (line_q && (cell_c_q != '0))                   rgb_d = GRID_RGB;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
      hit_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hit_q <= in_board_q;
    end
  end

  assign hit   = hit_q;
  assign red   = rgb_q[23:16];
  assign green = rgb_q[15:8];
  assign blue  = rgb_q[7:0];

endmodule

// File: tb/tb_playfield_renderer.sv
// Directed bench for playfield_renderer: pixel vector table, palette write hazard,
// full flash sequence, and reset/re-request during a flash.
module tb_playfield_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync_start = 1'b0;
  logic        blank_n = 1'b0;
  logic [8:0]  row = '0;
  logic [9:0]  column = '0;
  logic [7:0]  cell_addr;
  logic [2:0]  cell_code = '0;
  logic        flash_req = 1'b0;
  logic [19:0] flash_rows = '0;
  logic        flash_busy, flash_done;
  logic        pal_we = 1'b0;
  logic [2:0]  pal_idx = '0;
  logic [23:0] pal_data = '0;
  logic        hit;
  logic [7:0]  red, green, blue;

  logic [2:0]  board [0:199];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  playfield_renderer dut (
    .clk(clk), .rst(rst), .vsync_start(vsync_start), .blank_n(blank_n),
    .row(row), .column(column), .cell_addr(cell_addr), .cell_code(cell_code),
    .flash_req(flash_req), .flash_rows(flash_rows), .flash_busy(flash_busy),
    .flash_done(flash_done), .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .hit(hit), .red(red), .green(green), .blue(blue)
  );

  // Board RAM model with one-cycle read latency.
  always @(posedge clk) cell_code <= board[cell_addr];

  typedef struct {
    string       name;
    int          r;
    int          c;
    bit          b;
    logic [7:0]  addr;
    logic [23:0] rgb;
    bit          hit;
    bit          hchk;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one pixel for a single cycle, then a blanked pixel; output sampled two edges later.
  task automatic pixel(input int r, input int c, input bit b,
                       output logic [7:0] addr, output logic [23:0] rgb, output logic h);
    @(negedge clk); row = 9'(r); column = 10'(c); blank_n = b;
    #1 addr = cell_addr;
    @(negedge clk); row = '0; column = '0; blank_n = 1'b0;
    @(posedge clk); #1 rgb = {red, green, blue}; h = hit;
  endtask

  task automatic vpulse(output logic d, output logic bsy);
    @(negedge clk); vsync_start = 1'b1;
    @(posedge clk); #1 d = flash_done; bsy = flash_busy;
    @(negedge clk); vsync_start = 1'b0;
  endtask

  initial begin
    logic [7:0]  a;
    logic [23:0] rgb;
    logic        h, d, bsy;
    int          done_seen;

    for (int i = 0; i < 200; i++) board[i] = 3'd0;
    board[0] = 3'd3; board[9] = 3'd7; board[12] = 3'd5; board[86] = 3'd1; board[190] = 3'd2;

    vecs[0]  = '{"corner_code3", 40, 220, 1, 8'd0,   24'h7F00FF, 1, 1};
    vecs[1]  = '{"last_cell",    439, 419, 1, 8'd199, 24'hFFCCE5, 1, 1};
    vecs[2]  = '{"grid_col1",    439, 240, 1, 8'd191, 24'hFFBEF0, 1, 1};
    vecs[3]  = '{"right_out",    439, 440, 1, 8'd0,   24'h000000, 0, 1};
    vecs[4]  = '{"right_edge",   439, 420, 1, 8'd0,   24'h000000, 0, 1};
    vecs[5]  = '{"left_edge",    40,  219, 1, 8'd0,   24'h000000, 0, 1};
    vecs[6]  = '{"top_edge",     39,  220, 1, 8'd0,   24'h000000, 0, 1};
    vecs[7]  = '{"bottom_edge",  440, 220, 1, 8'd0,   24'h000000, 0, 1};
    vecs[8]  = '{"code5_online", 60,  260, 1, 8'd12,  24'h66FF66, 1, 1};
    vecs[9]  = '{"grid_col4",    80,  300, 1, 8'd24,  24'hFFBEF0, 1, 1};
    vecs[10] = '{"code7",        40,  400, 1, 8'd9,   24'h99FFCC, 1, 1};
    vecs[11] = '{"code1",        200, 340, 1, 8'd86,  24'h66B2FF, 1, 1};
    vecs[12] = '{"code2_row19",  420, 220, 1, 8'd190, 24'hFF3399, 1, 1};
    vecs[13] = '{"col0_no_grid", 100, 220, 1, 8'd30,  24'hFFCCE5, 1, 1};
    vecs[14] = '{"blanked",      40,  220, 0, 8'd0,   24'h000000, 0, 0};
    vecs[15] = '{"cell_interior",41,  239, 1, 8'd0,   24'h7F00FF, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb",  {8'd0, red, green, blue}, 32'd0);
    check("rst_hit",  32'(hit), 32'd0);
    check("rst_busy", 32'(flash_busy), 32'd0);
    check("rst_done", 32'(flash_done), 32'd0);
    @(negedge clk) rst = 1'b1;

    foreach (vecs[i]) begin
      pixel(vecs[i].r, vecs[i].c, vecs[i].b, a, rgb, h);
      check({vecs[i].name, "_addr"}, 32'(a), 32'(vecs[i].addr));
      check({vecs[i].name, "_rgb"},  32'(rgb), 32'(vecs[i].rgb));
      if (vecs[i].hchk) check({vecs[i].name, "_hit"}, 32'(h), 32'(vecs[i].hit));
    end

    // Palette write while the same index is being read in stage 2.
    @(negedge clk); row = 9'd40; column = 10'd220; blank_n = 1'b1;
    @(negedge clk); row = 9'd41; column = 10'd221;
    pal_we = 1'b1; pal_idx = 3'd3; pal_data = 24'h123456;
    @(posedge clk); #1 check("pal_same_cycle_old", 32'({red, green, blue}), 32'h7F00FF);
    @(negedge clk); pal_we = 1'b0; row = '0; column = '0; blank_n = 1'b0;
    @(posedge clk); #1 check("pal_next_new", 32'({red, green, blue}), 32'h123456);
    @(negedge clk); pal_we = 1'b1; pal_data = 24'h7F00FF;
    @(negedge clk); pal_we = 1'b0;

    // Request with no rows flagged is ignored.
    @(negedge clk); flash_req = 1'b1; flash_rows = '0;
    @(posedge clk); #1 check("req_zero_rows_busy", 32'(flash_busy), 32'd0);
    @(negedge clk); flash_req = 1'b0;

    // Full flash of row 19: ON frames 1-4, 9-12, 17-20.
    @(negedge clk); flash_req = 1'b1; flash_rows = 20'h80000;
    @(negedge clk); flash_req = 1'b0; flash_rows = '0;
    for (int k = 0; k < 24; k++) begin
      pixel(420, 220, 1'b1, a, rgb, h);
      check($sformatf("flash_rgb_f%0d", k + 1), 32'(rgb),
            ((k / 4) % 2 == 0) ? 32'hFFFFFF : 32'hFFCCE5);
      check($sformatf("flash_busy_f%0d", k + 1), 32'(flash_busy), 32'd1);
      if (k == 5) begin
        pixel(40, 220, 1'b1, a, rgb, h);
        check("flash_other_row", 32'(rgb), 32'h7F00FF);
      end
      vpulse(d, bsy);
      check($sformatf("flash_done_p%0d", k + 1), 32'(d), (k == 23) ? 32'd1 : 32'd0);
      if (k == 23) check("flash_busy_end", 32'(bsy), 32'd0);
    end
    @(posedge clk); #1 check("flash_done_one_cycle", 32'(flash_done), 32'd0);
    pixel(420, 220, 1'b1, a, rgb, h);
    check("after_flash_row19", 32'(rgb), 32'hFF3399);

    // Re-request while busy, then reset mid-flash.
    @(negedge clk); flash_req = 1'b1; flash_rows = 20'h80000;
    @(negedge clk); flash_req = 1'b0; flash_rows = '0;
    for (int k = 0; k < 6; k++) vpulse(d, bsy);
    @(negedge clk); flash_req = 1'b1; flash_rows = 20'h00001;
    @(negedge clk); flash_req = 1'b0; flash_rows = '0;
    check("rereq_busy", 32'(flash_busy), 32'd1);
    pixel(40, 220, 1'b1, a, rgb, h);
    check("rereq_row0_normal", 32'(rgb), 32'h7F00FF);
    pixel(420, 220, 1'b1, a, rgb, h);
    check("rereq_row19_off", 32'(rgb), 32'hFFCCE5);
    @(negedge clk); rst = 1'b0;
    #1 check("abort_busy", 32'(flash_busy), 32'd0);
    check("abort_done", 32'(flash_done), 32'd0);
    @(negedge clk); rst = 1'b1;
    pixel(420, 220, 1'b1, a, rgb, h);
    check("abort_row19_normal", 32'(rgb), 32'hFF3399);
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      vpulse(d, bsy);
      if (d === 1'b1 || bsy !== 1'b0) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
